// File: rtl/wgt_loader.sv
// Weight loader: fetches 3x3 kernels (three packed words each) from weight memory
// and presents them to the weight buffer one kernel at a time, on downstream request.
module wgt_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_kernels,
  input  logic                  next,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] wgt_input0,
  output logic [DATA_WIDTH-1:0] wgt_input1,
  output logic [DATA_WIDTH-1:0] wgt_input2,
  output logic                  wgt_read,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, HOLD, FIN} state_t;

  state_t                         state;
  logic [CNT_WIDTH-1:0]           k;
  logic [CNT_WIDTH-1:0]           n_lat;
  logic [1:0]                     w;
  logic [ADDR_WIDTH-1:0]          kbase;
  logic                           cap_vld;
  logic [1:0]                     cap_idx;
  logic [2:0][DATA_WIDTH-1:0]     wgt;

  assign wgt_input0 = wgt[0];
  assign wgt_input1 = wgt[1];
  assign wgt_input2 = wgt[2];

  // kbase tracks base + 3*k modulo 2^ADDR_WIDTH, avoiding a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      n_lat    <= '0;
      w        <= '0;
      kbase    <= '0;
      cap_vld  <= 1'b0;
      cap_idx  <= '0;
      wgt      <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      wgt_read <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort && state != IDLE) begin
      // In-flight read data is dropped by clearing the capture slot.
      state    <= IDLE;
      cap_vld  <= 1'b0;
      mem_en   <= 1'b0;
      wgt_read <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cap_vld <= mem_en;
      cap_idx <= w;
      if (cap_vld) wgt[cap_idx] <= mem_rdata;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (num_kernels != '0) begin
            state    <= FETCH;
            n_lat    <= num_kernels;
            kbase    <= base_addr;
            k        <= '0;
            w        <= '0;
            mem_en   <= 1'b1;
            mem_addr <= base_addr;
          end else begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FETCH: begin
          if (w == 2'd2) begin
            state  <= DRAIN;
            mem_en <= 1'b0;
          end else begin
            w        <= w + 2'd1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          state    <= PRESENT;
          wgt_read <= 1'b1;
        end
        PRESENT: begin
          wgt_read <= 1'b0;
          if (k == n_lat - 1'b1) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            k     <= k + 1'b1;
            kbase <= kbase + ADDR_WIDTH'(3);
            state <= HOLD;
          end
        end
        HOLD: if (next) begin
          state    <= FETCH;
          w        <= '0;
          mem_en   <= 1'b1;
          mem_addr <= kbase;
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
